// File: rtl/rd_burst_checker_if.sv
// Bus bundle for the rd/wr burst checker: channel strobes in,
// per-channel verdicts and aggregate counters out.
interface rd_burst_checker_if #(
  parameter int NUM_CH  = 1,
  parameter int MAX_LEN = 5,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 2);

  logic [NUM_CH-1:0]             ch_en;
  logic [NUM_CH-1:0]             wr;
  logic [NUM_CH-1:0]             rd;
  logic [NUM_CH-1:0]             pass_o;
  logic [NUM_CH-1:0]             fail_o;
  logic [NUM_CH-1:0][1:0]        fail_code;
  logic [NUM_CH-1:0][LEN_W-1:0]  last_len;
  logic [CNT_W-1:0]              pass_cnt;
  logic [CNT_W-1:0]              fail_cnt;

  modport master (
    output ch_en, wr, rd,
    input  pass_o, fail_o, fail_code,
    input  last_len, pass_cnt, fail_cnt
  );

  modport slave (
    input  ch_en, wr, rd,
    output pass_o, fail_o, fail_code,
    output last_len, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/rd_burst_checker.sv
// Multi-channel wr->rd burst monitor: per-channel FSM grading each rd
// burst length, with pass/fail pulses and saturating event counters.
module rd_burst_checker #(
  parameter int NUM_CH  = 1,
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 5,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  rd_burst_checker_if.slave   bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int SUM_W = CNT_W + PC_W;

  localparam logic [1:0] UNARMED = 2'd0;
  localparam logic [1:0] SHORT   = 2'd1;
  localparam logic [1:0] OVERRUN = 2'd2;
  localparam logic [1:0] COLLIDE = 2'd3;

  typedef enum logic [1:0] {
    IDLE, ARMED, BURST, WAIT_LOW
  } state_t;

  state_t            st     [NUM_CH];
  state_t            st_nxt [NUM_CH];
  logic [LEN_W-1:0]  cnt    [NUM_CH];
  logic [LEN_W-1:0]  cnt_nxt[NUM_CH];

  logic [NUM_CH-1:0]            pass_ev, fail_ev;
  logic [NUM_CH-1:0][1:0]       code_ev;
  logic [NUM_CH-1:0][LEN_W-1:0] len_ev;

  logic [NUM_CH-1:0]            pass_q, fail_q;
  logic [NUM_CH-1:0][1:0]       code_q;
  logic [NUM_CH-1:0][LEN_W-1:0] len_q;

  logic [PC_W-1:0]  pass_add, fail_add;
  logic [SUM_W-1:0] pass_sum, fail_sum;

  always_comb begin
    pass_ev = '0;
    fail_ev = '0;
    code_ev = '0;
    len_ev  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = cnt[i];
      if (!bus.ch_en[i]) begin
        st_nxt[i]  = IDLE;
        cnt_nxt[i] = '0;
      end else begin
        unique case (st[i])
          IDLE: begin
            if (bus.rd[i]) begin
              fail_ev[i] = 1'b1;
              code_ev[i] = UNARMED;
              st_nxt[i]  = WAIT_LOW;
            end else if (bus.wr[i]) begin
              st_nxt[i]  = ARMED;
            end
          end
          ARMED: begin
            if (bus.rd[i]) begin
              st_nxt[i]  = BURST;
              cnt_nxt[i] = LEN_W'(1);
            end
          end
          BURST: begin
            // collision outranks anything rd is doing this cycle
            if (bus.wr[i]) begin
              fail_ev[i] = 1'b1;
              code_ev[i] = COLLIDE;
              len_ev[i]  = cnt[i];
              st_nxt[i]  = WAIT_LOW;
              cnt_nxt[i] = '0;
            end else if (bus.rd[i]) begin
              if (cnt[i] >= LEN_W'(MAX_LEN)) begin
                fail_ev[i] = 1'b1;
                code_ev[i] = OVERRUN;
                len_ev[i]  = LEN_W'(MAX_LEN + 1);
                st_nxt[i]  = WAIT_LOW;
                cnt_nxt[i] = '0;
              end else begin
                cnt_nxt[i] = cnt[i] + LEN_W'(1);
              end
            end else begin
              len_ev[i]  = cnt[i];
              st_nxt[i]  = IDLE;
              cnt_nxt[i] = '0;
              if (cnt[i] >= LEN_W'(MIN_LEN)) begin
                pass_ev[i] = 1'b1;
              end else begin
                fail_ev[i] = 1'b1;
                code_ev[i] = SHORT;
              end
            end
          end
          WAIT_LOW: begin
            if (!bus.rd[i]) begin
              st_nxt[i] = bus.wr[i] ? ARMED : IDLE;
            end
          end
          default: st_nxt[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pass_add = '0;
    fail_add = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_add = pass_add + PC_W'(pass_q[i]);
      fail_add = fail_add + PC_W'(fail_q[i]);
    end
    pass_sum = SUM_W'(bus.pass_cnt) + SUM_W'(pass_add);
    fail_sum = SUM_W'(bus.fail_cnt) + SUM_W'(fail_add);
  end

  // verdicts are staged once so pulses land one clock after the decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      pass_q        <= '0;
      fail_q        <= '0;
      code_q        <= '0;
      len_q         <= '0;
      bus.pass_o    <= '0;
      bus.fail_o    <= '0;
      bus.fail_code <= '0;
      bus.last_len  <= '0;
      bus.pass_cnt  <= '0;
      bus.fail_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
        if (fail_q[i])
          bus.fail_code[i] <= code_q[i];
        if (fail_q[i] || pass_q[i])
          bus.last_len[i] <= len_q[i];
      end
      pass_q     <= pass_ev;
      fail_q     <= fail_ev;
      code_q     <= code_ev;
      len_q      <= len_ev;
      bus.pass_o <= pass_q;
      bus.fail_o <= fail_q;
      bus.pass_cnt <= (pass_sum[SUM_W-1:CNT_W] != '0)
                    ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
      bus.fail_cnt <= (fail_sum[SUM_W-1:CNT_W] != '0)
                    ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_rd_burst_checker.sv
// Directed bench: two-channel checker plus a one-channel,
// 2-bit-counter instance for saturation.
module tb_rd_burst_checker;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rd_burst_checker_if #(.NUM_CH(2)) ia ();
  rd_burst_checker_if #(.NUM_CH(1), .CNT_W(2)) ib ();

  rd_burst_checker #(
    .NUM_CH(2), .MIN_LEN(2), .MAX_LEN(5), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );

  rd_burst_checker #(
    .NUM_CH(1), .MIN_LEN(2), .MAX_LEN(5), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] w,
                      input logic [1:0] r,
                      input logic bw = 1'b0,
                      input logic br = 1'b0);
    ia.wr = w;
    ia.rd = r;
    ib.wr = bw;
    ib.rd = br;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ia.ch_en = 2'b11;
    ia.wr = '0;
    ia.rd = '0;
    ib.ch_en = 1'b1;
    ib.wr = '0;
    ib.rd = '0;
    #3;
    chk("rst_pass_o", 32'(ia.pass_o), 0);
    chk("rst_fail_o", 32'(ia.fail_o), 0);
    chk("rst_pass_cnt", 32'(ia.pass_cnt), 0);
    chk("rst_fail_cnt", 32'(ia.fail_cnt), 0);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    rst = 1'b0;
    step(2'b00, 2'b00);

    // 1: wr, three high samples, fall
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);
    repeat (3) step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    chk("t1_no_early", 32'(ia.pass_o), 0);
    step(2'b00, 2'b00);
    chk("t1_pass_o", 32'(ia.pass_o), 32'h1);
    chk("t1_fail_o", 32'(ia.fail_o), 0);
    chk("t1_len", 32'(ia.last_len[0]), 3);
    chk("t1_pcnt", 32'(ia.pass_cnt), 1);
    step(2'b00, 2'b00);
    chk("t1_one_cycle", 32'(ia.pass_o), 0);

    // 2: short burst, then minimum legal burst
    step(2'b01, 2'b00);
    step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t2_fail_o", 32'(ia.fail_o), 32'h1);
    chk("t2_code", 32'(ia.fail_code[0]), 1);
    chk("t2_len", 32'(ia.last_len[0]), 1);
    chk("t2_fcnt", 32'(ia.fail_cnt), 1);
    step(2'b01, 2'b00);
    repeat (2) step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t2_pass_o", 32'(ia.pass_o), 32'h1);
    chk("t2_len2", 32'(ia.last_len[0]), 2);
    chk("t2_pcnt", 32'(ia.pass_cnt), 2);

    // 3: eight high samples, overrun on the sixth
    step(2'b01, 2'b00);
    repeat (6) step(2'b00, 2'b01);
    chk("t3_not_yet", 32'(ia.fail_o), 0);
    step(2'b00, 2'b01);
    chk("t3_fail_o", 32'(ia.fail_o), 32'h1);
    chk("t3_code", 32'(ia.fail_code[0]), 2);
    chk("t3_len", 32'(ia.last_len[0]), 6);
    chk("t3_fcnt", 32'(ia.fail_cnt), 2);
    step(2'b00, 2'b01);
    chk("t3_quiet_hi", 32'(ia.fail_o), 0);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t3_quiet_fall_f", 32'(ia.fail_o), 0);
    chk("t3_quiet_fall_p", 32'(ia.pass_o), 0);
    step(2'b01, 2'b00);
    repeat (4) step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t3_pass_o", 32'(ia.pass_o), 32'h1);
    chk("t3_len4", 32'(ia.last_len[0]), 4);
    chk("t3_pcnt", 32'(ia.pass_cnt), 3);

    // 4: unarmed rise, then wr during burst
    step(2'b00, 2'b01);
    step(2'b00, 2'b01);
    chk("t4_unarmed_f", 32'(ia.fail_o), 32'h1);
    chk("t4_unarmed_c", 32'(ia.fail_code[0]), 0);
    chk("t4_unarmed_l", 32'(ia.last_len[0]), 0);
    chk("t4_fcnt", 32'(ia.fail_cnt), 3);
    step(2'b00, 2'b00);
    step(2'b01, 2'b00);
    step(2'b00, 2'b01);
    step(2'b01, 2'b01);
    step(2'b00, 2'b01);
    chk("t4_collide_f", 32'(ia.fail_o), 32'h1);
    chk("t4_collide_c", 32'(ia.fail_code[0]), 3);
    chk("t4_fcnt2", 32'(ia.fail_cnt), 4);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);

    // 5: both channels pass on the same cycle
    step(2'b11, 2'b00);
    repeat (3) step(2'b00, 2'b11);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t5_pass_both", 32'(ia.pass_o), 32'h3);
    chk("t5_len_c1", 32'(ia.last_len[1]), 3);
    chk("t5_pcnt", 32'(ia.pass_cnt), 5);

    // 5b: five passes into a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      step(2'b00, 2'b00, 1'b1, 1'b0);
      repeat (2) step(2'b00, 2'b00, 1'b0, 1'b1);
      step(2'b00, 2'b00, 1'b0, 1'b0);
    end
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t5_sat_pcnt", 32'(ib.pass_cnt), 3);
    chk("t5_sat_fcnt", 32'(ib.fail_cnt), 0);

    // 6: channel 0 disabled mid-burst
    step(2'b01, 2'b00);
    repeat (2) step(2'b00, 2'b01);
    ia.ch_en = 2'b10;
    step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    chk("t6_en_f", 32'(ia.fail_o), 0);
    chk("t6_en_p", 32'(ia.pass_o), 0);
    step(2'b00, 2'b00);
    chk("t6_en_f2", 32'(ia.fail_o), 0);
    chk("t6_en_pcnt", 32'(ia.pass_cnt), 5);
    chk("t6_en_fcnt", 32'(ia.fail_cnt), 4);
    ia.ch_en = 2'b11;
    step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    chk("t6_idle_f", 32'(ia.fail_o), 32'h1);
    chk("t6_idle_c", 32'(ia.fail_code[0]), 0);
    step(2'b00, 2'b00);

    // 6: async reset mid-burst
    step(2'b01, 2'b00);
    repeat (2) step(2'b00, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_pcnt", 32'(ia.pass_cnt), 0);
    chk("t6_rst_fcnt", 32'(ia.fail_cnt), 0);
    chk("t6_rst_len", 32'(ia.last_len[0]), 0);
    chk("t6_rst_code", 32'(ia.fail_code[0]), 0);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    rst = 1'b0;
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t6_rst_quiet_p", 32'(ia.pass_o), 0);
    chk("t6_rst_quiet_f", 32'(ia.fail_o), 0);
    step(2'b01, 2'b00);
    repeat (2) step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t6_post_pass", 32'(ia.pass_o), 32'h1);
    chk("t6_post_pcnt", 32'(ia.pass_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
